gate_resp_compactor: RTL and testbench
======================================

// Module: gate_resp_compactor
// PURPOSE
//  Downstream stage of the 16-in/10-out gate model: compacts its 10-bit output responses
//  into a multiple-input signature register (MISR) over a programmed pattern count, then
//  compares against a golden signature. Provides the pass/fail verdict for simulator self-tests.
// PARAMETERS
//  RESP_W   10        response width (gate model output count)
//  SIG_W    16        signature width; must be >= RESP_W
//  POLY     16'h1021  MISR feedback polynomial (bit i set = tap on bit i)
//  SEED     16'h0000  signature value loaded on start
//  CNT_W    16        pattern counter width
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       reset, asynchronous, active-high
//  start         in   1       begin a run; samples num_patterns, golden
//  abort         in   1       return to IDLE from any state
//  num_patterns  in   CNT_W   responses to compact in this run
//  golden        in   SIG_W   expected final signature
//  resp_valid    in   1       response word present
//  resp_data     in   RESP_W  gate model outputs
//  resp_ready    out  1       stage accepts response (high only in RUN)
//  busy          out  1       high in RUN
//  done          out  1       high in DONE
//  pass          out  1       signature == golden; valid while done
//  signature     out  SIG_W   current MISR contents
//  count         out  CNT_W   responses accepted in current run
// BEHAVIOUR
//  - Reset: state=IDLE; resp_ready=0, busy=0, done=0, pass=0, signature=SEED, count=0.
//  - FSM IDLE -> RUN on start (num_patterns!=0); IDLE -> DONE on start with num_patterns==0.
//    RUN -> DONE the cycle after the num_patterns-th accept. DONE -> RUN/DONE on new start.
//    abort wins over start and over accept; any state -> IDLE, signature/count keep value.
//  - On start: signature<=SEED, count<=0, num_patterns and golden latched internally.
//  - Accept = resp_valid & resp_ready; one word per cycle, no bubble required.
//  - MISR per accept: sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0)
//    ^ zero-extend(resp_data). No update without accept.
//  - count increments per accept, saturates at latched num_patterns.
//  - pass registered on RUN->DONE (or IDLE->DONE) transition: signature == latched golden;
//    held stable through DONE; cleared on start or abort.
//  - resp_valid outside RUN is ignored; start during RUN is ignored.
//  - Latency: final accept at cycle t -> done=1, pass valid at t+1.
// CONFIGURATION
//  RESP_COMPACTOR_MASK_EN defined: extra input resp_mask [RESP_W-1:0], sampled on start;
//   MISR uses resp_data & ~mask (masks unknown/don't-care outputs).
//  Undefined: port absent, all response bits compacted.
// STRUCTURE
//  - Package gate_bist_pkg: state enum {IDLE,RUN,DONE}, RESP_W=10, DEFAULT_POLY=16'h1021,
//    DEFAULT_SEED, misr_step() function shared with the upstream pattern generator.
//  - One sub-module misr_core (load, enable, data -> sig); FSM/counter/compare in top.
// TESTING
//  1 SEED=0, N=1, resp 10'h001 -> signature 16'h0001, done=1 next cycle, golden 16'h0001 -> pass=1.
//  2 SEED=16'h8000, N=1, resp 0 -> signature 16'h1021; golden 16'h1020 -> pass=0.
//  3 N=4, resp_valid toggling 1,0,1,0,... -> exactly 4 accepts, count=4, no update on idle cycles.
//  4 N=0 start -> DONE next cycle, signature=SEED, pass=(golden==SEED).
//  5 abort after 2 of 5 accepts -> IDLE, resp_ready=0; later start restarts from SEED, count=0.
//  6 rst asserted mid-RUN (async, off clock edge) -> all outputs to reset values immediately.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared BIST types and the MISR step function, also used by the upstream pattern generator.
package gate_bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int          RESP_W       = 10;
    localparam logic [15:0] DEFAULT_POLY = 16'h1021;
    localparam logic [15:0] DEFAULT_SEED = 16'h0000;

    // Width-generic step over a 64-bit container; bits at and above w are cleared.
    function automatic logic [63:0] misr_step(input logic [63:0] sig, input logic [63:0] poly,
                                              input logic [63:0] data, input int w);
        logic [63:0] mask;
        logic        msb;
        mask      = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        msb       = sig[6'(w - 1)];
        misr_step = ((sig << 1) ^ (msb ? poly : 64'd0) ^ data) & mask;
    endfunction

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: loads SEED on load, folds data in on enable.
module misr_core #(
    parameter int              SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0] SEED = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] nxt
);
    import gate_bist_pkg::*;

    assign nxt = SIG_W'(misr_step(64'(sig), 64'(POLY), 64'(data), SIG_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       sig <= SEED;
        else if (load) sig <= SEED;
        else if (en)   sig <= nxt;
    end

endmodule

// File: rtl/gate_resp_compactor.sv
// Compacts gate-model responses into a MISR over a programmed pattern count and checks the golden
// signature. Define RESP_COMPACTOR_MASK_EN to add resp_mask (masked bits are not compacted).
module gate_resp_compactor #(
    parameter int               RESP_W = gate_bist_pkg::RESP_W,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(gate_bist_pkg::DEFAULT_POLY),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(gate_bist_pkg::DEFAULT_SEED),
    parameter int               CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_patterns,
    input  logic [SIG_W-1:0]  golden,
`ifdef RESP_COMPACTOR_MASK_EN
    input  logic [RESP_W-1:0] resp_mask,
`endif
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_data,
    output logic              resp_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  count
);
    import gate_bist_pkg::*;

    state_t            state;
    logic [CNT_W-1:0]  n_q;
    logic [SIG_W-1:0]  golden_q;
    logic [SIG_W-1:0]  sig_nxt;
    logic [SIG_W-1:0]  din;
    logic              go, acc, last;

    // start is ignored while running; abort overrides both start and accept
    assign go   = start & ~abort & (state != RUN);
    assign acc  = resp_valid & resp_ready & ~abort;
    assign last = acc & ((count + CNT_W'(1)) == n_q);

`ifdef RESP_COMPACTOR_MASK_EN
    logic [RESP_W-1:0] mask_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     mask_q <= '0;
        else if (go) mask_q <= resp_mask;
    end
    assign din = SIG_W'(resp_data & ~mask_q);
`else
    assign din = SIG_W'(resp_data);
`endif

    misr_core #(.SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (go),
        .en   (acc),
        .data (din),
        .sig  (signature),
        .nxt  (sig_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            resp_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            count      <= '0;
            n_q        <= '0;
            golden_q   <= '0;
        end else if (abort) begin
            state      <= IDLE;
            resp_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (go) begin
            count    <= '0;
            n_q      <= num_patterns;
            golden_q <= golden;
            if (num_patterns == '0) begin
                state      <= DONE;
                resp_ready <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
                pass       <= (SEED == golden);
            end else begin
                state      <= RUN;
                resp_ready <= 1'b1;
                busy       <= 1'b1;
                done       <= 1'b0;
                pass       <= 1'b0;
            end
        end else if (acc) begin
            if (count != n_q) count <= count + CNT_W'(1);
            if (last) begin
                // compare against the post-update signature so pass lines up with done
                state      <= DONE;
                resp_ready <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
                pass       <= (sig_nxt == golden_q);
            end
        end
    end

endmodule

// File: tb/tb_gate_resp_compactor.sv
// Directed bench for gate_resp_compactor: two instances (SEED 0 and SEED 16'h8000) share stimulus.
module tb_gate_resp_compactor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic [15:0] num_patterns, golden;
    logic        resp_valid;
    logic [9:0]  resp_data;
`ifdef RESP_COMPACTOR_MASK_EN
    logic [9:0]  resp_mask = '0;
`endif

    logic        ready0, busy0, done0, pass0;
    logic [15:0] sig0, cnt0;
    logic        ready1, busy1, done1, pass1;
    logic [15:0] sig1, cnt1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gate_resp_compactor #(.SEED(16'h0000)) u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_patterns(num_patterns), .golden(golden),
`ifdef RESP_COMPACTOR_MASK_EN
        .resp_mask(resp_mask),
`endif
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_ready(ready0), .busy(busy0), .done(done0), .pass(pass0),
        .signature(sig0), .count(cnt0)
    );

    gate_resp_compactor #(.SEED(16'h8000)) u1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_patterns(num_patterns), .golden(golden),
`ifdef RESP_COMPACTOR_MASK_EN
        .resp_mask(resp_mask),
`endif
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_ready(ready1), .busy(busy1), .done(done1), .pass(pass1),
        .signature(sig1), .count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_patterns = '0; golden = '0;
        resp_valid = 1'b0; resp_data = '0;
        tick(); tick();
        chk("rst_ready", 32'(ready0), 0);
        chk("rst_busy",  32'(busy0),  0);
        chk("rst_done",  32'(done0),  0);
        chk("rst_pass",  32'(pass0),  0);
        chk("rst_sig0",  32'(sig0),   32'h0000);
        chk("rst_sig1",  32'(sig1),   32'h8000);
        chk("rst_cnt",   32'(cnt0),   0);
        rst = 1'b0;
        tick();

        // 1: seed 0, one response 10'h001
        num_patterns = 16'd1; golden = 16'h0001; start = 1'b1;
        tick(); start = 1'b0;
        chk("t1_busy",  32'(busy0),  1);
        chk("t1_ready", 32'(ready0), 1);
        chk("t1_cnt0",  32'(cnt0),   0);
        resp_valid = 1'b1; resp_data = 10'h001;
        tick(); resp_valid = 1'b0;
        chk("t1_done",  32'(done0), 1);
        chk("t1_sig",   32'(sig0),  32'h0001);
        chk("t1_pass",  32'(pass0), 1);
        chk("t1_cnt",   32'(cnt0),  1);
        chk("t1_busy0", 32'(busy0), 0);

        // 2: seed 8000, response 0 -> poly feedback only
        num_patterns = 16'd1; golden = 16'h1020; start = 1'b1;
        tick(); start = 1'b0;
        chk("t2_load", 32'(sig1), 32'h8000);
        resp_valid = 1'b1; resp_data = 10'h000;
        tick(); resp_valid = 1'b0;
        chk("t2_sig",   32'(sig1),  32'h1021);
        chk("t2_done",  32'(done1), 1);
        chk("t2_pass",  32'(pass1), 0);
        chk("t2_pass0", 32'(pass0), 0);

        // 3: N=4 with valid toggling; junk data on idle cycles must not be compacted
        num_patterns = 16'd4; golden = 16'h0002; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            resp_valid = (i % 2 == 0);
            resp_data  = (i % 2 == 0) ? 10'(i / 2 + 1) : 10'h3FF;
            tick();
            if (i == 3) begin
                chk("t3_cnt_mid", 32'(cnt0), 2);
                chk("t3_sig_mid", 32'(sig0), 32'h0000);
            end
            if (i == 4) chk("t3_notdone", 32'(done0), 0);
            if (i == 6) chk("t3_done_lat", 32'(done0), 1);
        end
        chk("t3_cnt",  32'(cnt0),  4);
        chk("t3_sig",  32'(sig0),  32'h0002);
        chk("t3_pass", 32'(pass0), 1);
        resp_valid = 1'b1; resp_data = 10'h3FF;
        tick(); resp_valid = 1'b0;
        chk("t3_ign_sig", 32'(sig0), 32'h0002);
        chk("t3_ign_cnt", 32'(cnt0), 4);

        // 4: N=0 from DONE
        num_patterns = 16'd0; golden = 16'h0000; start = 1'b1;
        tick(); start = 1'b0;
        chk("t4_done0", 32'(done0), 1);
        chk("t4_busy0", 32'(busy0), 0);
        chk("t4_sig0",  32'(sig0),  32'h0000);
        chk("t4_pass0", 32'(pass0), 1);
        chk("t4_sig1",  32'(sig1),  32'h8000);
        chk("t4_pass1", 32'(pass1), 0);

        // 5: abort after 2 of 5 accepts; abort beats a simultaneous start and accept
        num_patterns = 16'd5; start = 1'b1;
        tick(); start = 1'b0;
        resp_valid = 1'b1; resp_data = 10'h001;
        tick(); tick();
        chk("t5_cnt2", 32'(cnt0), 2);
        chk("t5_sig2", 32'(sig0), 32'h0003);
        abort = 1'b1; start = 1'b1; num_patterns = 16'd1; resp_data = 10'h007;
        tick(); abort = 1'b0; start = 1'b0; resp_valid = 1'b0;
        chk("t5_ready", 32'(ready0), 0);
        chk("t5_busy",  32'(busy0),  0);
        chk("t5_done",  32'(done0),  0);
        chk("t5_hold",  32'(sig0),   32'h0003);
        chk("t5_hcnt",  32'(cnt0),   2);
        num_patterns = 16'd1; golden = 16'h0005; start = 1'b1;
        tick(); start = 1'b0;
        chk("t5_rs_cnt", 32'(cnt0), 0);
        chk("t5_rs_sig", 32'(sig0), 32'h0000);
        chk("t5_rs_bsy", 32'(busy0), 1);
        start = 1'b1; num_patterns = 16'd7; resp_valid = 1'b1; resp_data = 10'h005;
        tick(); start = 1'b0; resp_valid = 1'b0;
        chk("t5_fin_done", 32'(done0), 1);
        chk("t5_fin_sig",  32'(sig0),  32'h0005);
        chk("t5_fin_cnt",  32'(cnt0),  1);
        chk("t5_fin_pass", 32'(pass0), 1);

        // 6: async reset mid-RUN, off the clock edge
        num_patterns = 16'd3; golden = 16'h0000; start = 1'b1;
        tick(); start = 1'b0;
        resp_valid = 1'b1; resp_data = 10'h001;
        tick(); resp_valid = 1'b0;
        chk("t6_pre_cnt", 32'(cnt0), 1);
        #3 rst = 1'b1;
        #1;
        chk("t6_busy",  32'(busy0),  0);
        chk("t6_ready", 32'(ready0), 0);
        chk("t6_cnt",   32'(cnt0),   0);
        chk("t6_sig0",  32'(sig0),   32'h0000);
        chk("t6_sig1",  32'(sig1),   32'h8000);
        chk("t6_done",  32'(done0),  0);
        #2 rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
